// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants, counter widths and the downstream timing bundle for vga_timing_gen.
package vga_timing_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  // 800x600@60, 40 MHz pixel clock
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           hsync;
    logic           vsync;
    logic           hsync_de;
    logic           vsync_de;
    logic           de;
  } vga_timing_t;

  function automatic int axis_total(input int sync_len, input int bp, input int active, input int fp);
    return sync_len + bp + active + fp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: control inputs (ce/restart) in, counters, syncs, enables and strobes out.
// Carries frame_cnt only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic           ce;
  logic           restart;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           hsync;
  logic           vsync;
  logic           hsync_de;
  logic           vsync_de;
  logic           de;
  logic           line_start;
  logic           frame_start;
  vga_timing_t    timing;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0]     frame_cnt;
`endif

  modport master (
    input  ce, restart,
    output x_cnt, y_cnt, hsync, vsync, hsync_de, vsync_de, de,
           line_start, frame_start, timing
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    output ce, restart,
    input  x_cnt, y_cnt, hsync, vsync, hsync_de, vsync_de, de,
           line_start, frame_start, timing
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input frame_cnt
`endif
  );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with sync and display-enable windows,
// all registered from the next-state count so they align with the count they describe.
module vga_axis_counter #(
  parameter int W        = 11,
  parameter int TOTAL    = 1056,
  parameter int SYNC_LEN = 128,
  parameter int DE_START = 216,
  parameter int DE_END   = 1016
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_adv,
  input  logic         i_restart,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_sync,
  output logic         o_de,
  output logic         o_de_next
);

  localparam logic [W-1:0] C_LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] C_SYNC     = W'(SYNC_LEN);
  localparam logic [W-1:0] C_DE_START = W'(DE_START);
  localparam logic [W-1:0] C_DE_END   = W'(DE_END);
  localparam logic         RST_SYNC   = (SYNC_LEN > 0);
  localparam logic         RST_DE     = (DE_START == 0) && (DE_END > 0);

  logic [W-1:0] r_count;
  logic         r_sync;
  logic         r_de;
  logic [W-1:0] w_count_next;
  logic         w_sync_next;

  assign o_wrap = i_adv && (r_count == C_LAST);

  // restart beats advance; a restart coinciding with a wrap lands on 0 either way
  always_comb begin
    w_count_next = r_count;
    if (i_restart)
      w_count_next = '0;
    else if (i_adv)
      w_count_next = (r_count == C_LAST) ? '0 : r_count + 1'b1;
  end

  assign w_sync_next = (w_count_next < C_SYNC);
  assign o_de_next   = (w_count_next >= C_DE_START) && (w_count_next < C_DE_END);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_sync  <= RST_SYNC;
      r_de    <= RST_DE;
    end else begin
      r_count <= w_count_next;
      r_sync  <= w_sync_next;
      r_de    <= o_de_next;
    end
  end

  assign o_count = r_count;
  assign o_sync  = r_sync;
  assign o_de    = r_de;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator (default 800x600@60): counters, syncs, enables and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL   = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int HDE_START = H_SYNC + H_BP;
  localparam int HDE_END   = HDE_START + H_ACTIVE;
  localparam int V_TOTAL   = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int VDE_START = V_SYNC + V_BP;
  localparam int VDE_END   = VDE_START + V_ACTIVE;

  if (H_TOTAL > 2047 || V_TOTAL > 1023) begin : g_width_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the counter width");
  end

  logic [X_W-1:0] w_x_cnt;
  logic [Y_W-1:0] w_y_cnt;
  logic           w_h_wrap;
  logic           w_v_wrap;
  logic           w_h_sync;
  logic           w_v_sync;
  logic           w_h_de;
  logic           w_v_de;
  logic           w_h_de_next;
  logic           w_v_de_next;
  logic           r_de;
  logic           r_line_start;
  logic           r_frame_start;

  vga_axis_counter #(
    .W(X_W), .TOTAL(H_TOTAL), .SYNC_LEN(H_SYNC), .DE_START(HDE_START), .DE_END(HDE_END)
  ) u_h_axis (
    .i_clk(vga_clk), .i_rst_n(rst_n), .i_adv(bus.ce), .i_restart(bus.restart),
    .o_count(w_x_cnt), .o_wrap(w_h_wrap), .o_sync(w_h_sync), .o_de(w_h_de),
    .o_de_next(w_h_de_next)
  );

  // vertical axis steps only on the horizontal wrap, so its wrap marks the frame end
  vga_axis_counter #(
    .W(Y_W), .TOTAL(V_TOTAL), .SYNC_LEN(V_SYNC), .DE_START(VDE_START), .DE_END(VDE_END)
  ) u_v_axis (
    .i_clk(vga_clk), .i_rst_n(rst_n), .i_adv(w_h_wrap), .i_restart(bus.restart),
    .o_count(w_y_cnt), .o_wrap(w_v_wrap), .o_sync(w_v_sync), .o_de(w_v_de),
    .o_de_next(w_v_de_next)
  );

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_de          <= w_h_de_next & w_v_de_next;
      r_line_start  <= bus.restart | w_h_wrap;
      r_frame_start <= bus.restart | w_v_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)
      r_frame_cnt <= 8'd0;
    else if (bus.restart | w_v_wrap)
      r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  assign bus.frame_cnt = r_frame_cnt;
`endif

  assign bus.x_cnt       = w_x_cnt;
  assign bus.y_cnt       = w_y_cnt;
  assign bus.hsync       = HS_POL ? w_h_sync : ~w_h_sync;
  assign bus.vsync       = VS_POL ? w_v_sync : ~w_v_sync;
  assign bus.hsync_de    = w_h_de;
  assign bus.vsync_de    = w_v_de;
  assign bus.de          = r_de;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

  assign bus.timing = '{
    x_cnt:    w_x_cnt,
    y_cnt:    w_y_cnt,
    hsync:    bus.hsync,
    vsync:    bus.vsync,
    hsync_de: w_h_de,
    vsync_de: w_v_de,
    de:       r_de
  };

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the video path: produces the horizontal/vertical counters, sync pulses and display-enable windows that pixel sources (test card, OSD, frame readers) consume to generate `bar_data`-style pixel output. Default timing is 800x600@60 (40 MHz pixel clock). All pixel sources sample `x_cnt`/`y_cnt` on the opposite clock edge, so every output here is registered on the rising edge of `vga_clk`.

## Interface
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch, in pixels
- `H_SYNC`, 128, hsync pulse width, in pixels
- `H_BP`, 88, horizontal back porch, in pixels
- `V_ACTIVE`, 600, visible lines
- `V_FP`, 1, vertical front porch, in lines
- `V_SYNC`, 4, vsync pulse width, in lines
- `V_BP`, 23, vertical back porch, in lines
- `HS_POL`, 1, hsync active level
- `VS_POL`, 1, vsync active level
- `vga_clk`  in  1  pixel clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ce`  in  1  pixel clock enable; counters advance only when high
- `restart`  in  1  synchronous resync request; forces counters to (0,0)
- `x_cnt`  out  11  horizontal position, 0..H_TOTAL-1
- `y_cnt`  out  10  vertical position, 0..V_TOTAL-1
- `hsync`, `vsync`  out  1  sync outputs, polarity set by `HS_POL`/`VS_POL`
- `hsync_de`, `vsync_de`  out  1  horizontal/vertical active windows
- `de`  out  1  `hsync_de & vsync_de`
- `line_start`, `frame_start`  out  1  single-cycle strobes
- `frame_cnt`  out  8  frame counter (only with the macro defined)

## Operation
- Derived values: H_TOTAL = sum of the H parameters (1056); HDE_START = H_SYNC + H_BP (216); HDE_END = HDE_START + H_ACTIVE (1016). V_TOTAL is 628, VDE_START is 27 and VDE_END is 627, derived the same way.
- Line layout: sync, back porch, active, front porch. Cycle x = 0 starts the sync pulse.
- `x_cnt` increments each `ce` cycle and wraps from H_TOTAL-1 to 0. `y_cnt` increments only on that wrap and wraps from V_TOTAL-1 to 0.
- `hsync` is active while x < H_SYNC. `vsync` is active while y < V_SYNC.
- `hsync_de` is high for HDE_START ≤ x < HDE_END. `vsync_de` is high for VDE_START ≤ y < VDE_END.
- `line_start` is high for one cycle when the counters advance to x = 0. `frame_start` is high for one cycle when they advance to (0,0).
- `restart` has priority over `ce`. It loads (0,0) and pulses both `line_start` and `frame_start` in the following cycle.
- With `ce` low, all counters and levels hold, and both strobes are low.
- Width rule: no parameter set may give H_TOTAL > 2047 or V_TOTAL > 1023. An elaboration-time check enforces this.

## Timing
- Every output is registered and decoded from the next-state counter values. Sync, de and strobes are therefore cycle-aligned with the `x_cnt`/`y_cnt` they describe; there is no extra pipeline lag.
- Reset values:
  - `x_cnt` = 0, `y_cnt` = 0
  - `hsync` = `HS_POL`, `vsync` = `VS_POL` (position (0,0) is inside both sync pulses)
  - all de outputs = 0
  - strobes = 0; no strobe is issued out of reset
  - `frame_cnt` = 0
- First advance after reset: x goes 0→1.
- Reset asserted mid-frame: outputs go to reset values asynchronously.
- `restart` in the same cycle as a natural wrap: the result is identical to the wrap, and each strobe fires once, not twice.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: the 8-bit `frame_cnt` output exists. It increments (mod 256) in the same cycle `frame_start` is asserted, including `restart`. It does not increment out of reset.
- Macro undefined: the port and its register are absent. All other behaviour is unchanged.

## Structure
- Package `vga_timing_pkg` holds:
  - the 800x600 and 640x480 timing constant sets
  - counter width constants (11/10)
  - a `vga_timing_t` struct bundling `x_cnt`, `y_cnt`, `hsync`, `vsync`, `hsync_de`, `vsync_de` and `de`, for downstream ports
- One sub-module, `vga_axis_counter`, is instantiated twice: once horizontal, and once vertical with its advance tied to the horizontal wrap.
  - Parameters: total length, sync length, de start, de end.
  - Outputs: count, wrap, sync, de.

## Test plan
- Reset release, `ce`=1, defaults → `hsync` is active for x 0..127 and goes inactive at x = 128. `hsync_de` rises at x = 216 and falls at x = 1016. x wraps 1055→0 with `line_start` high on exactly that cycle.
- Run one full frame → `y_cnt` reaches 627 and wraps to 0. `frame_start` pulses once every 1056×628 = 663168 cycles. `vsync_de` is high for y 27..626 only.
- `ce` toggling 1-0-1 at x = 500 → all outputs frozen for the low cycle. No strobe is issued, and the count resumes at 501.
- `restart` at (700, 300) → the next cycle shows (0,0), with `line_start` = `frame_start` = 1, `hsync`/`vsync` active and `de` = 0. `restart` held together with an x = 1055, y = 627 wrap → single strobes only.
- `rst_n` asserted at (400, 100) mid-cycle → outputs immediately take reset values. After release, no strobe fires until the first real wrap.
- Macro defined, 3 frames plus one `restart` → `frame_cnt` = 4. Also rerun with `HS_POL` = 0 and `VS_POL` = 0 and confirm inverted sync levels.
